// File: rtl/draw_seq_pkg.sv
// draw_seq_pkg: shared state encoding, sizes and stage decode
// for the draw_sequencer frame controller.
package draw_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLEAR  = 4'd1,
    S_BG     = 4'd2,
    S_LEFT   = 4'd3,
    S_RIGHT  = 4'd4,
    S_BALL   = 4'd5,
    S_LGOAL  = 4'd6,
    S_RGOAL  = 4'd7,
    S_GROUND = 4'd8,
    S_FDONE  = 4'd9,
    S_WAIT   = 4'd10
  } state_e;

  localparam int NUM_STAGES   = 7;
  localparam int WDOG_DEFAULT = 131072;
  localparam int WDOG_W       = 18;
  localparam int TICK_W       = 8;
  localparam int OVR_W        = 8;

  // Bit i is the request for stage i, BG first, GROUND last.
  function automatic logic [NUM_STAGES-1:0] stage_onehot(
    input state_e s
  );
    logic [NUM_STAGES-1:0] v;
    v = '0;
    unique case (s)
      S_BG:     v[0] = 1'b1;
      S_LEFT:   v[1] = 1'b1;
      S_RIGHT:  v[2] = 1'b1;
      S_BALL:   v[3] = 1'b1;
      S_LGOAL:  v[4] = 1'b1;
      S_RGOAL:  v[5] = 1'b1;
      S_GROUND: v[6] = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/draw_sequencer_pacer.sv
// frame_pacer: one-deep tick pending latch, redraw divider
// and saturating overrun counter for draw_sequencer.
// Ports: clk, rst_n, busy, in_wait, frame_tick -> advance
// (combinational, WAIT only), overrun_cnt.
module frame_pacer
  import draw_seq_pkg::*;
#(
  parameter int FRAME_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy,
  input  logic             in_wait,
  input  logic             frame_tick,
  output logic             advance,
  output logic [OVR_W-1:0] overrun_cnt
);

  if (FRAME_DIV < 1 || FRAME_DIV > 255) begin : g_bad_div
    $error("frame_pacer: FRAME_DIV must be 1..255");
  end

  localparam logic [TICK_W:0] DIV = (TICK_W+1)'(FRAME_DIV);

  logic              pend_q, pend_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic [TICK_W:0]   sum;

  // In WAIT a live tick and the pending credit both count,
  // so one cycle can add two.
  always_comb begin
    sum = {1'b0, cnt_q}
        + (TICK_W+1)'(frame_tick)
        + (TICK_W+1)'(pend_q);
    advance = in_wait && (sum >= DIV);
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    if (in_wait) begin
      pend_d = 1'b0;
      cnt_d  = advance ? '0 : sum[TICK_W-1:0];
    end else if (busy && frame_tick) begin
      pend_d = 1'b1;
      if (pend_q && ovr_q != '1) begin
        ovr_d = ovr_q + OVR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
    end
  end

  assign overrun_cnt = ovr_q;

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame stage sequencer for the sprite
// datapath, paced by frame_tick through frame_pacer.
// Inputs: Clock, Resetn (async low), go, frame_tick,
// DoneDraw* sticky flags. Outputs: draw_* requests (one-hot0),
// dp_clear, frame_done, busy, overrun_cnt, err_timeout.
// Optional stage watchdog: define DRAW_SEQ_WATCHDOG_EN.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int FRAME_DIV   = 1,
  parameter int WDOG_CYCLES = WDOG_DEFAULT
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       go,
  input  logic       frame_tick,
  input  logic       DoneDrawBackground,
  input  logic       DoneDrawLPlayer,
  input  logic       DoneDrawRPlayer,
  input  logic       DoneDrawBall,
  input  logic       DoneDrawLGoal,
  input  logic       DoneDrawRGoal,
  input  logic       DoneDrawGround,
  output logic       draw_background,
  output logic       draw_left,
  output logic       draw_right,
  output logic       draw_ball,
  output logic       draw_lgoal,
  output logic       draw_rgoal,
  output logic       draw_ground,
  output logic       dp_clear,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] overrun_cnt,
  output logic       err_timeout
);

  if (WDOG_CYCLES < 2 || WDOG_CYCLES > (1 << WDOG_W))
  begin : g_bad_wdog
    $error("draw_sequencer: WDOG_CYCLES out of range");
  end

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] draw_vec, done_vec;
  logic                  stage_done;
  logic                  wdog_to;
  logic                  in_wait;
  logic                  advance;

  assign done_vec = {
    DoneDrawGround, DoneDrawRGoal, DoneDrawLGoal,
    DoneDrawBall, DoneDrawRPlayer, DoneDrawLPlayer,
    DoneDrawBackground
  };

  assign draw_vec   = stage_onehot(state_q);
  assign stage_done = |(draw_vec & done_vec);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_CLEAR;
      S_CLEAR: state_d = S_BG;
      S_BG, S_LEFT, S_RIGHT, S_BALL,
      S_LGOAL, S_RGOAL, S_GROUND: begin
        // Stage states are contiguous; GROUND+1 is FDONE.
        if (stage_done || wdog_to) begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
      S_FDONE: state_d = go ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!go)          state_d = S_IDLE;
        else if (advance) state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  assign draw_background = draw_vec[0];
  assign draw_left       = draw_vec[1];
  assign draw_right      = draw_vec[2];
  assign draw_ball       = draw_vec[3];
  assign draw_lgoal      = draw_vec[4];
  assign draw_rgoal      = draw_vec[5];
  assign draw_ground     = draw_vec[6];
  assign dp_clear        = (state_q == S_CLEAR);
  assign frame_done      = (state_q == S_FDONE);
  assign in_wait         = (state_q == S_WAIT);
  assign busy = !(state_q == S_IDLE || in_wait);

  frame_pacer #(
    .FRAME_DIV (FRAME_DIV)
  ) u_pacer (
    .clk         (Clock),
    .rst_n       (Resetn),
    .busy        (busy),
    .in_wait     (in_wait),
    .frame_tick  (frame_tick),
    .advance     (advance),
    .overrun_cnt (overrun_cnt)
  );

`ifdef DRAW_SEQ_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST =
    WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;

  assign wdog_to = (|draw_vec) && !stage_done
                && (wdog_q == WDOG_LAST);

  // Restart on every state change so each stage gets a
  // full budget.
  always_comb begin
    wdog_d = wdog_q + WDOG_W'(1);
    if (!(|draw_vec) || state_d != state_q) wdog_d = '0;
    err_d = err_q | wdog_to;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign wdog_to     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed bench with a datapath model
// and an event scoreboard for draw_sequencer.
module tb_draw_sequencer;

  logic       clk;
  logic       Resetn;
  logic       go;
  logic       frame_tick;
  logic [6:0] dp_done;
  logic [6:0] force_mask;
  logic [6:0] never_mask;
  logic [6:0] done_in;
  logic       draw_background, draw_left, draw_right;
  logic       draw_ball, draw_lgoal, draw_rgoal, draw_ground;
  logic       dp_clear, frame_done, busy, err_timeout;
  logic [7:0] overrun_cnt;
  logic [8:0] obs_code;
  logic [8:0] prev_code;
  logic [8:0] exp_q[$];
  int         dly;
  int         dcnt;
  int         n_checks;
  int         n_errors;
  int         n;

  assign done_in = dp_done | force_mask;
  assign obs_code = {
    frame_done, dp_clear, draw_ground, draw_rgoal,
    draw_lgoal, draw_ball, draw_right, draw_left,
    draw_background
  };

  draw_sequencer #(
    .FRAME_DIV   (2),
    .WDOG_CYCLES (64)
  ) dut (
    .Clock              (clk),
    .Resetn             (Resetn),
    .go                 (go),
    .frame_tick         (frame_tick),
    .DoneDrawBackground (done_in[0]),
    .DoneDrawLPlayer    (done_in[1]),
    .DoneDrawRPlayer    (done_in[2]),
    .DoneDrawBall       (done_in[3]),
    .DoneDrawLGoal      (done_in[4]),
    .DoneDrawRGoal      (done_in[5]),
    .DoneDrawGround     (done_in[6]),
    .draw_background    (draw_background),
    .draw_left          (draw_left),
    .draw_right         (draw_right),
    .draw_ball          (draw_ball),
    .draw_lgoal         (draw_lgoal),
    .draw_rgoal         (draw_rgoal),
    .draw_ground        (draw_ground),
    .dp_clear           (dp_clear),
    .frame_done         (frame_done),
    .busy               (busy),
    .overrun_cnt        (overrun_cnt),
    .err_timeout        (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int upto);
    exp_q.push_back(9'h080);
    for (int i = 0; i < upto; i++) exp_q.push_back(9'(1 << i));
    if (upto == 7) exp_q.push_back(9'h100);
  endtask

  task automatic wait_bit(input int which, input int budget,
                          input string tag);
    int k;
    k = 0;
    while (obs_code[which] !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(obs_code[which]), 32'd1);
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Datapath model: a stage's sticky done rises after it has
  // seen its request for dly cycles; dp_clear wipes all.
  always @(negedge clk) begin
    if (!Resetn || dp_clear) begin
      dp_done = '0;
      dcnt    = 0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (obs_code[i] && !dp_done[i] && !never_mask[i]) begin
          dcnt++;
          if (dcnt >= dly) begin
            dp_done[i] = 1'b1;
            dcnt       = 0;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every new nonzero output pattern
  // must match the next expected event.
  always @(negedge clk) begin
    if (!Resetn) begin
      prev_code = '0;
    end else begin
      check("busy", 32'(busy), 32'(obs_code != 9'h000));
      if (obs_code != prev_code) begin
        check("onehot", 32'($onehot0(obs_code)), 32'd1);
        if (obs_code != 9'h000) begin
          if (exp_q.size() == 0)
            check("unexpected", 32'(obs_code), 32'd0);
          else
            check("seq", 32'(obs_code), 32'(exp_q.pop_front()));
        end else begin
          check("gap", 32'(prev_code), 32'h100);
        end
      end
      prev_code = obs_code;
    end
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    Resetn     = 1'b0;
    go         = 1'b0;
    frame_tick = 1'b0;
    force_mask = '0;
    never_mask = '0;
    dp_done    = '0;
    prev_code  = '0;
    dly        = 400;
    dcnt       = 0;

    repeat (3) @(negedge clk);
    check("rst_outs", 32'(obs_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    Resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outs", 32'(obs_code), 32'd0);

    // Overrun saturation during a long BG, then reset mid-BG.
    push_frame(1);
    go = 1'b1;
    wait_bit(0, 10, "bg_start");
    frame_tick = 1'b1;
    repeat (200) @(negedge clk);
    check("ovr_200", 32'(overrun_cnt), 32'd199);
    repeat (56) @(negedge clk);
    check("ovr_256", 32'(overrun_cnt), 32'd255);
    repeat (44) @(negedge clk);
    check("ovr_sat", 32'(overrun_cnt), 32'd255);
    frame_tick = 1'b0;
    check("bg_held", 32'(draw_background), 32'd1);
    #2;
    Resetn = 1'b0;
    go     = 1'b0;
    #1;
    check("async_outs", 32'(obs_code), 32'd0);
    check("async_ovr", 32'(overrun_cnt), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 Resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_outs", 32'(obs_code), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ovr", 32'(overrun_cnt), 32'd0);

    // One frame, done 10 cycles after each request.
    dly = 10;
    push_frame(7);
    go = 1'b1;
    @(negedge clk);
    check("clear_n1", 32'(dp_clear), 32'd1);
    @(negedge clk);
    check("bg_n2", 32'(draw_background), 32'd1);
    n = 0;
    while (draw_background && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("bg_len", 32'(n), 32'd10);
    wait_bit(8, 200, "fdone1");
    @(negedge clk);
    check("fdone_len", 32'(frame_done), 32'd0);
    repeat (30) @(negedge clk);
    check("wait_idle", 32'(busy), 32'd0);
    check("sb_frame1", 32'(exp_q.size()), 32'd0);

    // FRAME_DIV=2 pacing: 297-cycle frames, ticks every 500.
    dly = 42;
    for (int k = 1; k <= 6; k++) begin
      if (k % 2 == 0) push_frame(7);
      repeat (499) @(negedge clk);
      check("pace_wait", 32'(busy), 32'd0);
      tick_pulse();
      check("pace_clear", 32'(dp_clear), 32'(k % 2 == 0));
    end
    go = 1'b0;
    wait_bit(8, 400, "pace_fdone");
    repeat (3) @(negedge clk);
    check("pace_ovr", 32'(overrun_cnt), 32'd0);
    check("pace_idle", 32'(busy), 32'd0);
    check("sb_pace", 32'(exp_q.size()), 32'd0);

    // Long frame: one tick pends, the next is an overrun.
    dly = 170;
    push_frame(7);
    go = 1'b1;
    wait_bit(0, 10, "long_bg");
    repeat (100) @(negedge clk);
    tick_pulse();
    check("pend_ovr0", 32'(overrun_cnt), 32'd0);
    check("pend_busy", 32'(busy), 32'd1);
    repeat (499) @(negedge clk);
    tick_pulse();
    check("ovr_one", 32'(overrun_cnt), 32'd1);
    wait_bit(8, 1500, "long_fdone");
    repeat (5) @(negedge clk);
    check("long_wait", 32'(busy), 32'd0);
    dly = 10;
    push_frame(7);
    tick_pulse();
    check("credit_clear", 32'(dp_clear), 32'd1);
    go = 1'b0;
    wait_bit(8, 200, "credit_fdone");
    repeat (20) @(negedge clk);
    check("credit_idle", 32'(busy), 32'd0);
    check("credit_ovr", 32'(overrun_cnt), 32'd1);
    check("sb_long", 32'(exp_q.size()), 32'd0);

    // LEFT done preset; go dropped during RIGHT.
    force_mask = 7'b0000010;
    push_frame(7);
    go = 1'b1;
    wait_bit(1, 40, "left_start");
    n = 0;
    while (draw_left && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("left_len", 32'(n), 32'd1);
    check("right_now", 32'(draw_right), 32'd1);
    go = 1'b0;
    wait_bit(8, 200, "drop_fdone");
    repeat (20) @(negedge clk);
    tick_pulse();
    repeat (20) @(negedge clk);
    check("drop_idle", 32'(obs_code), 32'd0);
    check("sb_drop", 32'(exp_q.size()), 32'd0);
    force_mask = '0;

    // Ball never completes.
    never_mask = 7'b0001000;
`ifdef DRAW_SEQ_WATCHDOG_EN
    push_frame(7);
`else
    push_frame(4);
`endif
    go = 1'b1;
    wait_bit(3, 100, "ball_start");
    check("err_before", 32'(err_timeout), 32'd0);
    n = 0;
    while (draw_ball && n < 300) begin
      n++;
      @(negedge clk);
    end
`ifdef DRAW_SEQ_WATCHDOG_EN
    check("wdog_len", 32'(n), 32'd64);
    check("wdog_err", 32'(err_timeout), 32'd1);
    check("wdog_lgoal", 32'(draw_lgoal), 32'd1);
    go = 1'b0;
    wait_bit(8, 200, "wdog_fdone");
    @(negedge clk);
    check("err_sticky", 32'(err_timeout), 32'd1);
`else
    check("ball_stuck", 32'(n), 32'd300);
    check("ball_held", 32'(draw_ball), 32'd1);
    check("no_err", 32'(err_timeout), 32'd0);
`endif
    check("sb_end", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Frame-level control FSM that sits directly upstream of the sprite-drawing datapath. Each frame it issues that block's `draw_*` requests one stage at a time, waits for the matching `DoneDraw*` flag, and clears the datapath between frames. It paces redraws from an external frame tick, so the screen is repainted at a fixed rate and overruns are detectable.

## Interface
Parameters:
- `FRAME_DIV`, 1: frame ticks per redraw (1..255); 2 gives a 30 Hz redraw from a 60 Hz tick.
- `WDOG_CYCLES`, 131072: maximum cycles allowed per stage before timeout (watchdog builds only).

Ports:
- `Clock`  in  1  system clock.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `go`  in  1  level; enables continuous redraw.
- `frame_tick`  in  1  single-cycle pulse, e.g. vsync.
- `DoneDrawBackground, DoneDrawLPlayer, DoneDrawRPlayer, DoneDrawBall, DoneDrawLGoal, DoneDrawRGoal, DoneDrawGround`  in  1 each  sticky done flags from the datapath.
- `draw_background, draw_left, draw_right, draw_ball, draw_lgoal, draw_rgoal, draw_ground`  out  1 each  stage requests, at most one high.
- `dp_clear`  out  1  one-cycle active-high pulse that clears the datapath's done flags and counters.
- `frame_done`  out  1  one-cycle pulse after the ground stage completes.
- `busy`  out  1  high in any state except IDLE and WAIT.
- `overrun_cnt`  out  8  saturating count of frame ticks dropped.
- `err_timeout`  out  1  sticky stage-timeout flag.

## Operation
- States, in order: IDLE, CLEAR, BG, LEFT, RIGHT, BALL, LGOAL, RGOAL, GROUND, FDONE, WAIT.
- IDLE: all outputs low. When `go`=1, go to CLEAR.
- CLEAR: `dp_clear`=1 for exactly one cycle, then go to BG.
- Stage states: only the stage's own `draw_*` is high. When its `DoneDraw*` is sampled high, move to the next stage; the `draw_*` drops on the same edge.
- The stage chain is BG→LEFT→RIGHT→BALL→LGOAL→RGOAL→GROUND.
- GROUND done goes to FDONE, which pulses `frame_done` for one cycle, then:
  - to WAIT if `go`=1;
  - to IDLE otherwise.
- WAIT counts accepted ticks. When the count reaches `FRAME_DIV`, clear the count and go to CLEAR.
- Tick pending latch (one-deep):
  - A `frame_tick` arriving while `busy` sets `pending`.
  - On entering WAIT, a set `pending` counts as one tick and is cleared.
  - A tick arriving while `pending` is already set increments `overrun_cnt`, saturating at 255.
- A tick in WAIT and a pending credit on the same cycle count as two ticks.
- Dropping `go` mid-frame does not abort; the current frame completes, then the FSM goes to IDLE.
- A done flag already high on entry to its stage advances after one cycle, so the request is asserted for a minimum of one cycle.
- Reset, at any time: state=IDLE and all outputs 0, including `overrun_cnt`, `err_timeout`, `pending` and the tick count.

## Timing
- All outputs are registered and decoded from the state register.
- `go` asserted at edge N: CLEAR at N+1 with `dp_clear` high; BG at N+2 with `draw_background` high.
- Done sampled at edge M: next `draw_*` is high after M+1; no gap cycle and no overlap between stages.
- FDONE lasts exactly one cycle.
- WAIT→CLEAR occurs on the edge where the tick that reaches `FRAME_DIV` is sampled.
- Tick count width is 8 bits; `FRAME_DIV`=0 is illegal and is checked by an elaboration assertion.

## Configuration
- `DRAW_SEQ_WATCHDOG_EN` defined:
  - an 18-bit stage counter resets on every stage entry;
  - when it reaches `WDOG_CYCLES`−1 without a done, set `err_timeout` (sticky until reset) and advance to the next stage as if done were seen.
- `DRAW_SEQ_WATCHDOG_EN` undefined: no counter is built, `err_timeout` is tied 0, and the FSM waits on done indefinitely.

## Structure
- Package `draw_seq_pkg`:
  - state encoding constants;
  - stage count (7);
  - default `WDOG_CYCLES`;
  - counter widths.
- Sub-module `frame_pacer`: holds the pending latch, the tick divider and the overrun counter. Its interface is inputs `busy`, `in_wait`, `frame_tick` and outputs `advance`, `overrun_cnt`. The top level keeps the FSM and the watchdog.

## Test plan
- Reset mid-BG, then release → all outputs 0, `overrun_cnt`=0, FSM in IDLE.
- `go`=1; a datapath model returns each done 10 cycles after its request → seven requests in order, each with no overlap; `frame_done` pulses once; then WAIT.
- `FRAME_DIV`=2, ticks every 500 cycles, frame takes 300 cycles → CLEAR on every second tick; `overrun_cnt` stays 0.
- Frame takes 1200 cycles with ticks every 500 → one tick pends; the second extra tick gives `overrun_cnt`=1; the pending tick is consumed on WAIT entry.
- `go` dropped during RIGHT → BALL through GROUND still run, `frame_done` pulses, then IDLE with no CLEAR.
- Watchdog build, `WDOG_CYCLES`=64, `DoneDrawBall` never set → after 64 cycles in BALL, `err_timeout`=1 and LGOAL is entered; in a non-watchdog build the FSM stays in BALL.
